// File: rtl/rmii_rx_deframer_pkg.sv
// rmii_rx_deframer_pkg: shared FSM states, CRC-32 constants and RMII dibit codes
package eth_rx_pkg;
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_t;
    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam logic [1:0] PRE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT = 2'b11;
endpackage

// File: rtl/rmii_rx_deframer_if.sv
// rmii_rx_deframer_if: byte-wide payload stream without back-pressure
interface rmii_rx_deframer_if;
    logic tvalid;
    logic [7:0] tdata;
    logic tlast;
    logic tuser;
    modport master(output tvalid, tdata, tlast, tuser);
    modport slave(input tvalid, tdata, tlast, tuser);
endinterface

// File: rtl/rmii_rx_deframer_crc32_dibit.sv
// crc32_dibit: reflected CRC-32 advanced by one dibit, bit 0 first
module crc32_dibit
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_next
);
    logic [31:0] c1;
    // two serial LFSR steps, earliest wire bit first
    always_comb begin
        c1 = (crc >> 1) ^ ((crc[0] ^ dibit[0]) ? CRC32_POLY : 32'h0);
        crc_next = (c1 >> 1) ^ ((c1[0] ^ dibit[1]) ? CRC32_POLY : 32'h0);
    end
endmodule

// File: rtl/rmii_rx_deframer.sv
// rmii_rx_deframer: RMII receive deframer stripping preamble/SFD/FCS into a byte stream
module rmii_rx_deframer
    import eth_rx_pkg::*;
#(
    parameter int MAX_BYTES = 1522
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               eth_rmii_crs_dv,
    input  logic               eth_rmii_rx_er,
    input  logic [1:0]         eth_rmii_rxd,
    rmii_rx_deframer_if.master m_axis,
    output logic [15:0]        frames_ok_cnt,
    output logic [15:0]        frames_err_cnt
);
    logic        crs_q, er_q, crs_d, er_d;
    logic [1:0]  rxd_q, rxd_d;
    state_t      state, state_nx;
    logic [31:0] crc, crc_nx;
    logic [7:0]  byte_sr;
    logic [1:0]  dibit_cnt;
    logic [15:0] byte_cnt;
    logic [39:0] hold;
    logic        er_seen, fin, fin_runt, fin_bad;
    logic        eof, data_ok, byte_done, over, sfd, push, fin_beat;

    // the S1 dibit is judged with the S0 crs_dv as lookahead: two lows end the frame,
    // a lone low is still data
    assign eof = !crs_d && !crs_q;
    assign data_ok = state == DATA && !eof;
    assign byte_done = data_ok && dibit_cnt == 2'd3;
    assign over = byte_done && byte_cnt == 16'(MAX_BYTES);
    assign sfd = state == PREAMBLE && !eof && rxd_d == SFD_DIBIT;
    assign push = byte_done && byte_cnt >= 16'd5;
    assign fin_beat = fin && !fin_runt;

    crc32_dibit u_crc (.crc(crc), .dibit(rxd_d), .crc_next(crc_nx));

    // next-state decode of the framing FSM
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = (crs_d && rxd_d == PRE_DIBIT) ? PREAMBLE : IDLE;
            PREAMBLE: state_nx = eof ? IDLE : (rxd_d == PRE_DIBIT) ? PREAMBLE : sfd ? DATA : DISCARD;
            DATA:     state_nx = eof ? IDLE : over ? DISCARD : DATA;
            default:  state_nx = eof ? IDLE : DISCARD;
        endcase
    end

    // input registers (S0, S1) and FSM state
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            {crs_q, er_q, rxd_q, crs_d, er_d, rxd_d} <= '0;
            state <= IDLE;
        end else begin
            {crs_q, er_q, rxd_q} <= {eth_rmii_crs_dv, eth_rmii_rx_er, eth_rmii_rxd};
            {crs_d, er_d, rxd_d} <= {crs_q, er_q, rxd_q};
            state <= state_nx;
        end
    end

    // byte assembly, CRC, 5-byte holding line and the deferred end-of-frame verdict
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            crc <= '0;
            byte_sr <= '0;
            dibit_cnt <= '0;
            byte_cnt <= '0;
            hold <= '0;
            {er_seen, fin, fin_runt, fin_bad} <= '0;
        end else begin
            if (sfd) begin
                crc <= CRC32_INIT;
                dibit_cnt <= '0;
                byte_cnt <= '0;
                er_seen <= 1'b0;
            end
            if (data_ok) begin
                crc <= crc_nx;
                byte_sr <= {rxd_d, byte_sr[7:2]};
                dibit_cnt <= dibit_cnt + 2'd1;
                er_seen <= er_seen | er_d;
            end
            if (byte_done) begin
                hold <= {hold[31:0], rxd_d, byte_sr[7:2]};
                byte_cnt <= byte_cnt + 16'd1;
            end
            fin <= state == DATA && eof;
            fin_runt <= byte_cnt <= 16'd5;
            fin_bad <= crc != CRC32_RESIDUE || er_seen || dibit_cnt != 2'd0;
        end
    end

    // registered stream beats and frame counters
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata <= '0;
            m_axis.tlast <= 1'b0;
            m_axis.tuser <= 1'b0;
            frames_ok_cnt <= '0;
            frames_err_cnt <= '0;
        end else begin
            m_axis.tvalid <= push || fin_beat;
            m_axis.tdata <= (push || fin_beat) ? hold[39:32] : 8'h0;
            m_axis.tlast <= over || fin_beat;
            m_axis.tuser <= over || (fin_beat && fin_bad);
            frames_ok_cnt <= frames_ok_cnt + 16'(fin_beat && !fin_bad);
            frames_err_cnt <= frames_err_cnt + 16'(over || (fin && (fin_runt || fin_bad)));
        end
    end
endmodule
